// File: rtl/seq_div_16x8_if.sv
// Operand/result handshake bundle for seq_div_16x8.
// slave = divider side, master = producer/consumer side.
interface seq_div_16x8_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_div_16x8.sv
// 16/8 unsigned radix-2 restoring divider, one quotient bit per clock.
// Macro SEQ_DIV_APPROX_LSB_EN: divide dividend[15:4] only, quotient[3:0] forced to 0.
module seq_div_16x8 (
    input  logic          clk,
    input  logic          rst_n,
    seq_div_16x8_if.slave dif
);

`ifdef SEQ_DIV_APPROX_LSB_EN
    localparam logic [4:0] LAST_ITER = 5'd11;
`else
    localparam logic [4:0] LAST_ITER = 5'd15;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q,   cnt_d;
    logic [8:0]  prem_q,  prem_d;
    logic [15:0] work_q,  work_d;
    logic [7:0]  dvs_q,   dvs_d;
    logic [15:0] quo_q,   quo_d;
    logic [7:0]  rem_q,   rem_d;
    logic        dbz_q,   dbz_d;

    logic        accept;
    logic [8:0]  trial;
    logic [8:0]  diff;
    logic        take;

    assign accept = dif.in_valid && (state_q == IDLE);

    // work_q shifts dividend bits out of the top while quotient bits enter at the bottom
    assign trial = {prem_q[7:0], work_q[15]};
    assign diff  = trial - {1'b0, dvs_q};
    assign take  = prem_q[8] || (trial >= {1'b0, dvs_q});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        work_d  = work_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    work_d = dif.dividend;
                    dvs_d  = dif.divisor;
                    prem_d = '0;
                    cnt_d  = '0;
                    if (dif.divisor == 8'd0) begin
                        state_d = DONE;
                        quo_d   = 16'hFFFF;
                        rem_d   = dif.dividend[7:0];
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                prem_d = take ? diff : trial;
                work_d = {work_q[14:0], take};
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                    cnt_d   = '0;
`ifdef SEQ_DIV_APPROX_LSB_EN
                    quo_d   = {work_q[10:0], take, 4'b0000};
`else
                    quo_d   = {work_q[14:0], take};
`endif
                    rem_d   = prem_d[7:0];
                    dbz_d   = 1'b0;
                end
            end
            DONE: begin
                if (dif.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            work_q  <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            work_q  <= work_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign dif.in_ready    = (state_q == IDLE);
    assign dif.out_valid   = (state_q == DONE);
    assign dif.quotient    = quo_q;
    assign dif.remainder   = rem_q;
    assign dif.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_16x8.sv
// Randomized and directed bench for seq_div_16x8 against an arithmetic reference model.
// Build with SEQ_DIV_APPROX_LSB_EN to check the approximate divider.
module tb_seq_div_16x8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    seq_div_16x8_if dif();

    seq_div_16x8 u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dif   (dif)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef SEQ_DIV_APPROX_LSB_EN
    localparam int ITERS = 12;
    localparam logic [15:0] Q_1000_7   = 16'h0080;
    localparam logic [7:0]  R_1000_7   = 8'd6;
    localparam logic [15:0] Q_FFFF_FF  = 16'd256;
    localparam logic [7:0]  R_FFFF_FF  = 8'd15;
    localparam logic [15:0] Q_FFFF_1   = 16'hFFF0;
`else
    localparam int ITERS = 16;
    localparam logic [15:0] Q_1000_7   = 16'd142;
    localparam logic [7:0]  R_1000_7   = 8'd6;
    localparam logic [15:0] Q_FFFF_FF  = 16'd257;
    localparam logic [7:0]  R_FFFF_FF  = 8'd0;
    localparam logic [15:0] Q_FFFF_1   = 16'd65535;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                  output logic [15:0] q, output logic [7:0] r, output logic z);
        int ai, bi;
        ai = int'(a);
        bi = int'(b);
        if (bi == 0) begin
            q = 16'hFFFF;
            r = a[7:0];
            z = 1'b1;
        end else begin
`ifdef SEQ_DIV_APPROX_LSB_EN
            q = 16'(((ai / 16) / bi) * 16);
            r = 8'((ai / 16) % bi);
`else
            q = 16'(ai / bi);
            r = 8'(ai % bi);
`endif
            z = 1'b0;
        end
    endfunction

    // lat counts rising edges from the accepting edge (inclusive) until out_valid is seen
    task automatic run_op(input logic [15:0] a, input logic [7:0] b, input int hold);
        logic [15:0] eq;
        logic [7:0]  er;
        logic        ez;
        int          lat;
        model(a, b, eq, er, ez);
        chk("idle_ready", dif.in_ready, 1);
        dif.dividend = a;
        dif.divisor  = b;
        dif.in_valid = 1'b1;
        @(posedge clk); #1;
        if (b != 8'd0) chk("busy_ready", dif.in_ready, 0);
        dif.dividend = 16'($urandom);
        dif.divisor  = 8'($urandom);
        lat = 1;
        while (!dif.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, (b == 8'd0) ? 1 : ITERS + 1);
        chk("quotient", dif.quotient, eq);
        chk("remainder", dif.remainder, er);
        chk("div_by_zero", dif.div_by_zero, ez);
        for (int i = 0; i < hold; i++) begin
            dif.in_valid = 1'b1;
            dif.dividend = 16'($urandom);
            dif.divisor  = 8'($urandom);
            @(posedge clk); #1;
            chk("bp_valid", dif.out_valid, 1);
            chk("bp_in_ready", dif.in_ready, 0);
            chk("bp_quotient", dif.quotient, eq);
            chk("bp_remainder", dif.remainder, er);
            chk("bp_dbz", dif.div_by_zero, ez);
        end
        dif.in_valid  = 1'b0;
        dif.out_ready = 1'b1;
        @(posedge clk); #1;
        dif.out_ready = 1'b0;
        chk("rel_in_ready", dif.in_ready, 1);
        chk("rel_out_valid", dif.out_valid, 0);
        chk("rel_quotient_kept", dif.quotient, eq);
    endtask

    initial begin
        dif.in_valid  = 1'b0;
        dif.out_ready = 1'b0;
        dif.dividend  = '0;
        dif.divisor   = '0;
        #12;
        chk("rst_in_ready", dif.in_ready, 1);
        chk("rst_out_valid", dif.out_valid, 0);
        chk("rst_quotient", dif.quotient, 0);
        chk("rst_remainder", dif.remainder, 0);
        chk("rst_dbz", dif.div_by_zero, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", dif.in_ready, 1);
        chk("post_rst_out_valid", dif.out_valid, 0);

        run_op(16'd1000, 8'd7, 0);
        chk("q_1000_7", dif.quotient, Q_1000_7);
        chk("r_1000_7", dif.remainder, R_1000_7);
        run_op(16'd65535, 8'd255, 1);
        chk("q_ffff_ff", dif.quotient, Q_FFFF_FF);
        chk("r_ffff_ff", dif.remainder, R_FFFF_FF);
        run_op(16'd65535, 8'd1, 0);
        chk("q_ffff_1", dif.quotient, Q_FFFF_1);
        chk("r_ffff_1", dif.remainder, 0);
        run_op(16'd100, 8'd0, 5);
        chk("q_div0", dif.quotient, 16'hFFFF);
        chk("r_div0", dif.remainder, 8'h64);
        chk("z_div0", dif.div_by_zero, 1);
        run_op(16'd1000, 8'd7, 5);

        // abort mid-division with an asynchronous reset
        dif.dividend = 16'd1000;
        dif.divisor  = 8'd7;
        dif.in_valid = 1'b1;
        @(posedge clk); #1;
        dif.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", dif.in_ready, 1);
        chk("abort_out_valid", dif.out_valid, 0);
        chk("abort_quotient", dif.quotient, 0);
        chk("abort_remainder", dif.remainder, 0);
        chk("abort_dbz", dif.div_by_zero, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            chk("abort_no_result", dif.out_valid, 0);
        end
        run_op(16'd1000, 8'd7, 0);
        chk("q_after_abort", dif.quotient, Q_1000_7);
        chk("r_after_abort", dif.remainder, R_1000_7);

        for (int n = 0; n < 40; n++) begin
            logic [15:0] a;
            logic [7:0]  b;
            a = 16'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            run_op(a, b, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
